// File: rtl/serializador_nibbles.sv
// serializador_nibbles: feeder for bit_mayor. Accepts one pair of WIDTH-bit operands
// through a valid/ready handshake and shifts them out LSB-first, one bit pair per
// cycle. Because bit_mayor overwrites its selector on every differing bit, the
// LSB-first order leaves the selector on the most significant differing bit once
// the frame ends. `fin` strobes for the single cycle in which that result is final.
//
// Optional feature: define SERIAL_IGUALES_EN to add the frame_iguales output.
// It flags frames whose operands were equal, i.e. frames where the bit_mayor
// selector holds a stale value.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_L       in   asynchronous active-low reset
//   in_valid      in   operand pair present on in_a/in_b
//   in_a, in_b    in   WIDTH-bit operands
//   in_ready      out  block can accept a pair (registered)
//   bm_a, bm_b    out  serial operand bits toward bit_mayor (registered)
//   bit_valid     out  bm_a/bm_b carry a frame bit this cycle (registered)
//   fin           out  one-cycle end-of-frame strobe (registered)
//   frame_iguales out  operands were equal; valid with fin (SERIAL_IGUALES_EN only)

module serializador_nibbles #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             bm_a,
  output logic             bm_b,
  output logic             bit_valid,
  output logic             fin
`ifdef SERIAL_IGUALES_EN
  ,
  output logic             frame_iguales
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             in_ready_q, in_ready_d;
  logic             bm_a_q, bm_a_d;
  logic             bm_b_q, bm_b_d;
  logic             bit_valid_q, bit_valid_d;
  logic             fin_q, fin_d;
  logic             accept;

`ifdef SERIAL_IGUALES_EN
  logic             eq_q, eq_d;
  logic             iguales_q, iguales_d;
`endif

  // in_ready_q is only ever 1 in StIdle, so it alone qualifies the handshake.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    in_ready_d  = in_ready_q;
    bm_a_d      = bm_a_q;
    bm_b_d      = bm_b_q;
    bit_valid_d = bit_valid_q;
    fin_d       = 1'b0;
`ifdef SERIAL_IGUALES_EN
    eq_d        = eq_q;
    iguales_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // Idle drives 00 so bit_mayor holds its selector; in_ready rises on the
        // first edge after reset release.
        in_ready_d  = 1'b1;
        bm_a_d      = 1'b0;
        bm_b_d      = 1'b0;
        bit_valid_d = 1'b0;
        if (accept) begin
          state_d     = StShift;
          sh_a_d      = in_a;
          sh_b_d      = in_b;
          bm_a_d      = in_a[0];
          bm_b_d      = in_b[0];
          bit_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          cnt_d       = '0;
`ifdef SERIAL_IGUALES_EN
          eq_d        = (in_a == in_b);
`endif
        end
      end

      StShift: begin
        if (cnt_q == LastCnt) begin
          state_d     = StIdle;
          bm_a_d      = 1'b0;
          bm_b_d      = 1'b0;
          bit_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          fin_d       = 1'b1;
`ifdef SERIAL_IGUALES_EN
          iguales_d   = eq_q;
`endif
        end else begin
          // sh_*_q[0] is the bit currently on the wire; [1] is the next one.
          bm_a_d = sh_a_q[1];
          bm_b_d = sh_b_q[1];
          sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
          sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      in_ready_q  <= 1'b0;
      bm_a_q      <= 1'b0;
      bm_b_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      fin_q       <= 1'b0;
`ifdef SERIAL_IGUALES_EN
      eq_q        <= 1'b0;
      iguales_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      in_ready_q  <= in_ready_d;
      bm_a_q      <= bm_a_d;
      bm_b_q      <= bm_b_d;
      bit_valid_q <= bit_valid_d;
      fin_q       <= fin_d;
`ifdef SERIAL_IGUALES_EN
      eq_q        <= eq_d;
      iguales_q   <= iguales_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign bm_a      = bm_a_q;
  assign bm_b      = bm_b_q;
  assign bit_valid = bit_valid_q;
  assign fin       = fin_q;
`ifdef SERIAL_IGUALES_EN
  assign frame_iguales = iguales_q;
`endif

endmodule

// File: tb/tb_serializador_nibbles.sv
// Directed bench for serializador_nibbles: a WIDTH=4 and a WIDTH=8 instance, each
// feeding a small behavioural model of the bit_mayor selector.

module tb_serializador_nibbles;

  logic clk;
  logic reset_L;

  logic       iv4, ready4, bma4, bmb4, bv4, fin4;
  logic [3:0] a4, b4;
  logic       iv8, ready8, bma8, bmb8, bv8, fin8;
  logic [7:0] a8, b8;
  logic       fi4, fi8;

  logic sel4, sel8;

  int total;
  int passed;
  int failed;

  serializador_nibbles #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset_L   (reset_L),
    .in_valid  (iv4),
    .in_a      (a4),
    .in_b      (b4),
    .in_ready  (ready4),
    .bm_a      (bma4),
    .bm_b      (bmb4),
    .bit_valid (bv4),
    .fin       (fin4)
`ifdef SERIAL_IGUALES_EN
    ,
    .frame_iguales (fi4)
`endif
  );

  serializador_nibbles #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset_L   (reset_L),
    .in_valid  (iv8),
    .in_a      (a8),
    .in_b      (b8),
    .in_ready  (ready8),
    .bm_a      (bma8),
    .bm_b      (bmb8),
    .bit_valid (bv8),
    .fin       (fin8)
`ifdef SERIAL_IGUALES_EN
    ,
    .frame_iguales (fi8)
`endif
  );

`ifndef SERIAL_IGUALES_EN
  assign fi4 = 1'b0;
  assign fi8 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit_mayor selector: overwritten with bm_b whenever the two bits differ.
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel4 <= 1'b0;
      sel8 <= 1'b0;
    end else begin
      if (bma4 != bmb4) sel4 <= bmb4;
      if (bma8 != bmb8) sel8 <= bmb8;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full frame: handshake, WIDTH bit cycles, then the fin cycle.
  task automatic do_frame(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          input logic exp_sel, input logic exp_eq, input string name);
    int w;
    w = wide ? 8 : 4;
    @(negedge clk);
    chk({name, " ready_pre"}, wide ? ready8 : ready4, 1);
    if (wide) begin
      iv8 = 1'b1; a8 = a; b8 = b;
    end else begin
      iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0];
    end
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Input changes after the handshake must not leak into the frame.
        if (wide) begin
          iv8 = 1'b0; a8 = ~a; b8 = ~b;
        end else begin
          iv4 = 1'b0; a4 = ~a[3:0]; b4 = ~b[3:0];
        end
      end
      chk($sformatf("%s bit%0d bm_a", name, k), wide ? bma8 : bma4, a[k]);
      chk($sformatf("%s bit%0d bm_b", name, k), wide ? bmb8 : bmb4, b[k]);
      chk($sformatf("%s bit%0d bit_valid", name, k), wide ? bv8 : bv4, 1);
      chk($sformatf("%s bit%0d in_ready", name, k), wide ? ready8 : ready4, 0);
      chk($sformatf("%s bit%0d fin", name, k), wide ? fin8 : fin4, 0);
`ifdef SERIAL_IGUALES_EN
      chk($sformatf("%s bit%0d iguales", name, k), wide ? fi8 : fi4, 0);
`endif
    end
    @(negedge clk);
    chk({name, " fin"}, wide ? fin8 : fin4, 1);
    chk({name, " fin bit_valid"}, wide ? bv8 : bv4, 0);
    chk({name, " fin in_ready"}, wide ? ready8 : ready4, 1);
    chk({name, " fin bm_a"}, wide ? bma8 : bma4, 0);
    chk({name, " fin bm_b"}, wide ? bmb8 : bmb4, 0);
    chk({name, " selector"}, wide ? sel8 : sel4, exp_sel);
`ifdef SERIAL_IGUALES_EN
    chk({name, " iguales"}, wide ? fi8 : fi4, exp_eq);
`else
    if (exp_eq) chk({name, " iguales absent"}, wide ? fi8 : fi4, 0);
`endif
  endtask

  initial begin
    int fins;
    int bvs;
    total   = 0;
    passed  = 0;
    failed  = 0;
    reset_L = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0;
    iv8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst in_ready4", ready4, 0);
    chk("rst bm_a4", bma4, 0);
    chk("rst bm_b4", bmb4, 0);
    chk("rst bit_valid4", bv4, 0);
    chk("rst fin4", fin4, 0);
    chk("rst iguales4", fi4, 0);
    chk("rst in_ready8", ready8, 0);
    reset_L = 1'b1;
    @(negedge clk);
    chk("release in_ready4", ready4, 1);
    chk("release in_ready8", ready8, 1);
    chk("release fin4", fin4, 0);

    // Directed frames on the 4-bit instance.
    do_frame(1'b0, 8'h0A, 8'h06, 1'b0, 1'b0, "f_a_b");
    do_frame(1'b0, 8'h03, 8'h09, 1'b1, 1'b0, "f_3_9");
    do_frame(1'b0, 8'h05, 8'h05, 1'b1, 1'b1, "f_eq5");

    // Back-to-back: in_valid held high across three frames.
    fins = 0;
    bvs  = 0;
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'h3; b4 = 4'h9;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fin4) fins++;
      if (bv4) bvs++;
      if (c == 4 || c == 9 || c == 14) begin
        chk($sformatf("b2b c%0d fin", c), fin4, 1);
        chk($sformatf("b2b c%0d in_ready", c), ready4, 1);
      end
      if (c == 5 || c == 10) chk($sformatf("b2b c%0d restart", c), bv4, 1);
      if (c == 10) iv4 = 1'b0;
    end
    chk("b2b fin count", fins, 3);
    chk("b2b bit count", bvs, 12);
    chk("b2b selector", sel4, 1);

    // Reset in the middle of a frame.
    @(negedge clk);
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    chk("midrst bit1 bm_a", bma4, 1);
    #2 reset_L = 1'b0;
    #1;
    chk("midrst bm_a", bma4, 0);
    chk("midrst bm_b", bmb4, 0);
    chk("midrst bit_valid", bv4, 0);
    chk("midrst in_ready", ready4, 0);
    chk("midrst fin", fin4, 0);
    chk("midrst iguales", fi4, 0);
    @(negedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    chk("midrst ready before edge", ready4, 0);
    @(negedge clk);
    chk("midrst ready after edge", ready4, 1);
    chk("midrst no fin", fin4, 0);
    chk("midrst no bits", bv4, 0);
    do_frame(1'b0, 8'h01, 8'h02, 1'b1, 1'b0, "post_rst");

    // 8-bit instance: B is larger in every bit but the MSB, where A wins.
    do_frame(1'b1, 8'h80, 8'h7F, 1'b0, 1'b0, "w8");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
